dsm_sample_pacer: RTL

Rate-matching sample buffer upstream of `dsm_dac`. It accepts multi-bit samples from a producer (sine generator, host, DMA) over a valid/ready handshake and stores them in a small FIFO. It releases exactly one sample every OSR clocks as a held, registered `sample_out` that drives `dsm_dac.dsm_in`. Both the DSM and this block run on the single fast clock, which replaces the divided-clock feed to `dsm_dac`.

---
 rtl/dsm_sample_pacer.sv | 90 +++++++++
 1 files changed

// File: rtl/dsm_sample_pacer.sv
// dsm_sample_pacer: rate-matching sample FIFO that releases one sample every OSR clocks to dsm_dac
//
// Optional feature macro: DSM_PACER_UNDERRUN_CNT_EN adds a saturating underrun counter port.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   enable       pacing enable; low clears the pace counter and holds sample_out
//   s_valid      producer has a sample
//   s_ready      block can accept (not full, not in reset)
//   s_data       producer sample, unsigned offset-binary
//   sample_out   held sample feeding dsm_dac.dsm_in
//   sample_tick  one-cycle pulse: sample_out was just loaded from the FIFO
//   underrun     one-cycle pulse: a release slot found the FIFO empty
//   fill         current FIFO occupancy, 0..FIFO_DEPTH
//   underrun_cnt saturating count of underrun pulses (macro builds only)
module dsm_sample_pacer #(
    parameter int DATA_W     = 8,
    parameter int OSR        = 100,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    output logic [DATA_W-1:0]             sample_out,
    output logic                          sample_tick,
    output logic                          underrun,
`ifdef DSM_PACER_UNDERRUN_CNT_EN
    output logic [15:0]                   underrun_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fill
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(OSR);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;
    logic              slot;
    logic              empty;

    // Readiness is judged on registered occupancy only, so a full FIFO
    // refuses a push even when a pop lands in the same cycle.
    assign s_ready = rst_n && (fill != FW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign slot    = enable && (cnt == CW'(OSR - 1));
    assign empty   = (fill == '0);
    // Registered fill excludes this cycle's push: no bypass into a slot.
    assign pop     = slot && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            cnt         <= '0;
            sample_out  <= {1'b1, {(DATA_W-1){1'b0}}};
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fill        <= fill + FW'(push) - FW'(pop);
            cnt         <= (!enable || slot) ? '0 : cnt + 1'b1;
            sample_out  <= pop ? mem[rd_ptr] : sample_out;
            sample_tick <= pop;
            underrun    <= slot && empty;
        end
    end

`ifdef DSM_PACER_UNDERRUN_CNT_EN
    // Updated on the same edge that raises underrun, so the new count is
    // visible in the pulse cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) underrun_cnt <= '0;
        else if (slot && empty && underrun_cnt != 16'hffff) underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif
endmodule
